// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus bit meanings.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    A_ACK     = 3'd2,
    WR_BYTE   = 3'd3,
    WR_ACK    = 3'd4,
    RD_BYTE   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } i2c_slave_state_t;

  localparam logic I2C_RW_READ = 1'b1;
  localparam logic I2C_ACK     = 1'b0;

  // General call (7'h00) never matches, even if the target is configured with that address.
  function automatic logic addr_match(input logic [7:0] addr_rw, input logic [6:0] own);
    return (addr_rw[7:1] == own) && (addr_rw[7:1] != 7'h00);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Pad synchronizers for SCL/SDA plus one edge-detect flop; emits bus events in the clk domain.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_d, sda_d, scl_s, sda_s;

  // Reset to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
  assign sda       = sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target: address match, ACK generation, byte write to rx_* and byte read from tx_*.
import i2c_pkg::*;

module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h55,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda)
  );

  i2c_slave_state_t state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       rw;
  logic       mack;
  logic       byte_done;   // 8th SCL rise seen; the following fall ends the byte
  logic       rx_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      rw         <= 1'b0;
      mack       <= 1'b1;
      byte_done  <= 1'b0;
      rx_pending <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      if (rx_pending) begin
        rx_data    <= shift;
        rx_valid   <= 1'b1;
        rx_pending <= 1'b0;
      end

      // Bus conditions preempt any bit processing in the same cycle.
      if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else if (start_det) begin
        state     <= ADDR;
        sda_oe    <= 1'b0;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
      end else begin
        case (state)
          IDLE: ;

          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (addr_match(shift, SLAVE_ADDR)) begin
                state  <= A_ACK;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
              end else begin
                state  <= WAIT_STOP;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
              end
            end
          end

          A_ACK: begin
            if (scl_fall) begin
              if (rw == I2C_RW_READ) begin
                tx_req <= 1'b1;
                shift  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_BYTE;
              end
            end
          end

          WR_BYTE: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_done  <= 1'b1;
                rx_pending <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b1;
              state     <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= WR_BYTE;
            end
          end

          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end else if (scl_fall) begin
              if (byte_done) begin
                byte_done <= 1'b0;
                sda_oe    <= 1'b0;
                state     <= RD_ACK;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              mack <= sda;
            end else if (scl_fall) begin
              if (mack == I2C_ACK) begin
                tx_req <= 1'b1;
                shift  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= RD_BYTE;
              end else begin
                sda_oe <= 1'b0;
                busy   <= 1'b0;
                state  <= WAIT_STOP;
              end
            end
          end

          WAIT_STOP: sda_oe <= 1'b0;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
